pw_trigger_seq: RTL and testbench

Parametrised multi-pulse trigger sequencer, successor to the fixed 8-pulse trigger generator. On a single-cycle pattern-match pulse it emits a train of up to pNUM_PULSES pulses, each with its own delay and width, on O_trigger. The whole block runs in the trigger_clk domain; I_match is already synchronised upstream. Additions over the previous generation:
- one-shot arm/disarm mode
- abort
- per-train configuration snapshot
- busy/done/index status
- optional missed-match counter

---
 rtl/pw_trigger_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_pw_trigger_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_trigger_seq.sv
// Multi-pulse trigger sequencer: a train of up to pNUM_PULSES delayed pulses on O_trigger per match.
// Optional missed-match counter is enabled with the PW_TRIG_MISSED_CNT_EN macro.
module pw_trigger_seq #(
  parameter int unsigned pNUM_PULSES   = 8,
  parameter int unsigned pNUM_WIDTH    = 4,
  parameter int unsigned pDELAY_WIDTH  = 20,
  parameter int unsigned pWIDTH_WIDTH  = 17,
  parameter int unsigned pMISSED_WIDTH = 16
) (
  input  logic                                 trigger_clk,
  input  logic                                 reset_n,
  input  logic                                 I_match,
  input  logic                                 I_trigger_enable,
  input  logic                                 I_oneshot,
  input  logic                                 I_arm,
  input  logic                                 I_abort,
  input  logic [pNUM_PULSES*pDELAY_WIDTH-1:0]  I_trigger_delay,
  input  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0]  I_trigger_width,
  input  logic [pNUM_WIDTH-1:0]                I_num_triggers,
  output logic                                 O_trigger,
  output logic                                 O_busy,
  output logic                                 O_armed,
  output logic                                 O_done,
  output logic [pNUM_WIDTH-1:0]                O_pulse_index
`ifdef PW_TRIG_MISSED_CNT_EN
  ,
  output logic [pMISSED_WIDTH-1:0]             O_missed_count
`endif
);

  localparam int unsigned CntWidth = (pDELAY_WIDTH > pWIDTH_WIDTH) ? pDELAY_WIDTH : pWIDTH_WIDTH;
  localparam int unsigned SelWidth = (pNUM_PULSES > 1) ? $clog2(pNUM_PULSES) : 1;

  typedef enum logic [1:0] {StIdle, StDelay, StHigh} state_e;

  state_e state_q, state_d;

  logic [pDELAY_WIDTH-1:0] dly_in [pNUM_PULSES];
  logic [pWIDTH_WIDTH-1:0] wid_in [pNUM_PULSES];
  logic [pDELAY_WIDTH-1:0] dly_q  [pNUM_PULSES];
  logic [pWIDTH_WIDTH-1:0] wid_q  [pNUM_PULSES];
  logic [pNUM_WIDTH-1:0]   num_in, num_q;

  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic [pNUM_WIDTH-1:0]   idx_q, idx_d;
  logic                    trig_q, trig_d;
  logic                    busy_q, busy_d;
  logic                    armed_q, armed_d;
  logic                    done_q, done_d;

  logic                    match_valid;
  logic                    accept;
  logic                    snap_en;
  logic                    last_pulse;
  logic                    cnt_zero;
  logic [SelWidth-1:0]     cur_sel;
  logic [SelWidth-1:0]     nxt_sel;

  for (genvar k = 0; k < pNUM_PULSES; k++) begin : g_unpack
    assign dly_in[k] = I_trigger_delay[k*pDELAY_WIDTH +: pDELAY_WIDTH];
    assign wid_in[k] = I_trigger_width[k*pWIDTH_WIDTH +: pWIDTH_WIDTH];
  end

  // Requests above the compiled maximum are clamped rather than wrapped.
  assign num_in = (I_num_triggers > pNUM_WIDTH'(pNUM_PULSES)) ? pNUM_WIDTH'(pNUM_PULSES)
                                                              : I_num_triggers;

  assign match_valid = I_match & I_trigger_enable & ~I_abort;
  assign accept      = (state_q == StIdle) & match_valid & (~I_oneshot | armed_q) &
                       (num_in != '0);
  assign last_pulse  = (idx_q == num_q - pNUM_WIDTH'(1));
  assign cnt_zero    = (cnt_q == '0);
  assign cur_sel     = SelWidth'(idx_q);
  assign nxt_sel     = SelWidth'(idx_q + pNUM_WIDTH'(1));

  // Remaining-cycle count for a phase of max(v,1) cycles; zero means "last cycle of the phase".
  function automatic logic [CntWidth-1:0] len_m1(input logic [CntWidth-1:0] v);
    return (v == '0) ? '0 : v - CntWidth'(1);
  endfunction

  // State and registered outputs.
  always_ff @(posedge trigger_clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
      done_q  <= done_d;
    end
  end

  // Per-train configuration snapshot; only meaningful while a train runs.
  always_ff @(posedge trigger_clk) begin
    if (snap_en) begin
      for (int k = 0; k < pNUM_PULSES; k++) begin
        dly_q[k] <= dly_in[k];
        wid_q[k] <= wid_in[k];
      end
      num_q <= num_in;
    end
  end

  always_comb begin
    state_d = state_q;
    if (I_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = (dly_in[0] == '0) ? StHigh : StDelay;
          end
        end
        StDelay: begin
          if (cnt_zero) begin
            state_d = StHigh;
          end
        end
        StHigh: begin
          if (cnt_zero) begin
            state_d = last_pulse ? StIdle : StDelay;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    trig_d  = trig_q;
    busy_d  = busy_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    snap_en = 1'b0;

    if (I_arm) begin
      armed_d = 1'b1;
    end

    if (I_abort) begin
      trig_d  = 1'b0;
      busy_d  = 1'b0;
      armed_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            snap_en = 1'b1;
            busy_d  = 1'b1;
            idx_d   = '0;
            if (dly_in[0] == '0) begin
              trig_d = 1'b1;
              cnt_d  = len_m1(CntWidth'(wid_in[0]));
            end else begin
              trig_d = 1'b0;
              cnt_d  = len_m1(CntWidth'(dly_in[0]));
            end
          end
        end
        StDelay: begin
          if (cnt_zero) begin
            trig_d = 1'b1;
            cnt_d  = len_m1(CntWidth'(wid_q[cur_sel]));
          end else begin
            cnt_d = cnt_q - CntWidth'(1);
          end
        end
        StHigh: begin
          if (cnt_zero) begin
            trig_d = 1'b0;
            if (last_pulse) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              armed_d = 1'b0;
            end else begin
              idx_d = idx_q + pNUM_WIDTH'(1);
              // Inter-pulse gap is at least one cycle even for a zero delay.
              cnt_d = len_m1(CntWidth'(dly_q[nxt_sel]));
            end
          end else begin
            cnt_d = cnt_q - CntWidth'(1);
          end
        end
        default: begin
          trig_d = 1'b0;
          busy_d = 1'b0;
        end
      endcase
    end
  end

  assign O_trigger     = trig_q;
  assign O_busy        = busy_q;
  assign O_armed       = armed_q;
  assign O_done        = done_q;
  assign O_pulse_index = idx_q;

`ifdef PW_TRIG_MISSED_CNT_EN
  logic [pMISSED_WIDTH-1:0] missed_q;
  logic                     missed_ev;

  assign missed_ev = match_valid & (num_in != '0) & (busy_q | (I_oneshot & ~armed_q));

  always_ff @(posedge trigger_clk) begin
    if (!reset_n) begin
      missed_q <= '0;
    end else if (missed_ev && (missed_q != '1)) begin
      missed_q <= missed_q + pMISSED_WIDTH'(1);
    end
  end

  assign O_missed_count = missed_q;
`endif

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Bench for pw_trigger_seq: directed scenarios plus random stimulus against a pulse-timeline model.
module tb_pw_trigger_seq;

  localparam int NP = 8;
  localparam int NW = 4;
  localparam int DW = 5;
  localparam int WW = 4;
  localparam int MW = 16;
  localparam int MissMax = (1 << MW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, match, en, oneshot, arm, abort;
  logic [NP*DW-1:0] tdelay;
  logic [NP*WW-1:0] twidth;
  logic [NW-1:0]    ntrig;
  logic             trig, busy, armed, done;
  logic [NW-1:0]    pidx;
`ifdef PW_TRIG_MISSED_CNT_EN
  logic [MW-1:0]    missed;
`endif

  pw_trigger_seq #(
    .pNUM_PULSES  (NP),
    .pNUM_WIDTH   (NW),
    .pDELAY_WIDTH (DW),
    .pWIDTH_WIDTH (WW),
    .pMISSED_WIDTH(MW)
  ) dut (
    .trigger_clk     (clk),
    .reset_n         (reset_n),
    .I_match         (match),
    .I_trigger_enable(en),
    .I_oneshot       (oneshot),
    .I_arm           (arm),
    .I_abort         (abort),
    .I_trigger_delay (tdelay),
    .I_trigger_width (twidth),
    .I_num_triggers  (ntrig),
    .O_trigger       (trig),
    .O_busy          (busy),
    .O_armed         (armed),
    .O_done          (done),
    .O_pulse_index   (pidx)
`ifdef PW_TRIG_MISSED_CNT_EN
    ,
    .O_missed_count  (missed)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: a running train is a list of absolute-cycle high windows [hs, he].
  bit m_active, m_armed, m_done;
  int m_hs[NP];
  int m_he[NP];
  int m_n, m_tend, m_idx, m_missed;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int dfield(input int k);
    return int'(tdelay[k*DW +: DW]);
  endfunction

  function automatic int wfield(input int k);
    return int'(twidth[k*WW +: WW]);
  endfunction

  function automatic bit exp_trig();
    if (!m_active) return 1'b0;
    for (int k = 0; k < m_n; k++) begin
      if (cyc >= m_hs[k] && cyc <= m_he[k]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_edge();
    int  n_in;
    bit  mv, busy_b, armed_b;
    n_in    = (int'(ntrig) > NP) ? NP : int'(ntrig);
    mv      = match & en & ~abort;
    busy_b  = m_active;
    armed_b = m_armed;
    m_done  = 1'b0;
    if (!reset_n) begin
      m_active = 1'b0;
      m_armed  = 1'b0;
      m_idx    = 0;
      m_missed = 0;
      return;
    end
    if (mv && n_in > 0 && (busy_b || (oneshot && !armed_b)) && m_missed < MissMax) m_missed++;
    if (abort) begin
      m_active = 1'b0;
      m_armed  = 1'b0;
      return;
    end
    if (m_active && cyc == m_tend + 1) begin
      m_active = 1'b0;
      m_done   = 1'b1;
    end else if (!busy_b && mv && (!oneshot || armed_b) && n_in > 0) begin
      m_hs[0] = cyc + dfield(0);
      m_he[0] = m_hs[0] + max1(wfield(0)) - 1;
      for (int k = 1; k < n_in; k++) begin
        m_hs[k] = m_he[k-1] + max1(dfield(k)) + 1;
        m_he[k] = m_hs[k] + max1(wfield(k)) - 1;
      end
      m_n      = n_in;
      m_tend   = m_he[n_in-1];
      m_active = 1'b1;
    end
    if (arm) m_armed = 1'b1;
    if (m_done) m_armed = 1'b0;
    if (m_active) begin
      m_idx = 0;
      for (int k = 0; k < m_n - 1; k++) begin
        if (m_he[k] < cyc) m_idx++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_val("trigger", 32'(trig), 32'(exp_trig()));
    check_val("busy", 32'(busy), 32'(m_active));
    check_val("armed", 32'(armed), 32'(m_armed));
    check_val("done", 32'(done), 32'(m_done));
    check_val("pulse_index", 32'(pidx), 32'(m_idx));
`ifdef PW_TRIG_MISSED_CNT_EN
    check_val("missed_count", 32'(missed), 32'(m_missed));
`endif
  endtask

  task automatic set_uniform(input int d, input int w, input int n);
    for (int k = 0; k < NP; k++) begin
      tdelay[k*DW +: DW] = DW'(d);
      twidth[k*WW +: WW] = WW'(w);
    end
    ntrig = NW'(n);
  endtask

  task automatic pulse_match();
    match = 1'b1;
    tick();
    match = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  logic [15:0] tr_trig, tr_busy, tr_done;
  int          cnt, prev;

  initial begin
    reset_n = 1'b0; match = 1'b0; en = 1'b0; oneshot = 1'b0; arm = 1'b0; abort = 1'b0;
    tdelay = '0; twidth = '0; ntrig = '0;
    repeat (3) tick();
    check_val("reset_trigger", 32'(trig), 32'd0);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_index", 32'(pidx), 32'd0);
    reset_n = 1'b1;
    en      = 1'b1;
    repeat (2) tick();

    // Delays {3,2}, widths {4,0}, two pulses.
    set_uniform(0, 0, 2);
    tdelay[0 +: DW] = 5'd3; tdelay[DW +: DW] = 5'd2;
    twidth[0 +: WW] = 4'd4; twidth[WW +: WW] = 4'd0;
    tr_trig = '0; tr_busy = '0; tr_done = '0;
    match = 1'b1;
    for (int r = 0; r <= 11; r++) begin
      tick();
      match = 1'b0;
      tr_trig[r] = trig; tr_busy[r] = busy; tr_done[r] = done;
    end
    check_val("tp1_trig_trace", 32'(tr_trig), 32'h278);
    check_val("tp1_busy_trace", 32'(tr_busy), 32'h3ff);
    check_val("tp1_done_trace", 32'(tr_done), 32'h400);

    // Zero delay, width 1, back-to-back match on the done cycle.
    set_uniform(0, 1, 1);
    pulse_match();
    check_val("tp2_trig_first", 32'(trig), 32'd1);
    tick();
    check_val("tp2_done", 32'(done), 32'd1);
    pulse_match();
    check_val("tp2_b2b_trig", 32'(trig), 32'd1);
    repeat (3) tick();

    // One-shot arming.
    oneshot = 1'b1;
    set_uniform(1, 2, 2);
    pulse_match();
    check_val("tp3_disarmed_busy", 32'(busy), 32'd0);
    arm = 1'b1; tick(); arm = 1'b0;
    check_val("tp3_armed", 32'(armed), 32'd1);
    pulse_match();
    check_val("tp3_armed_busy", 32'(busy), 32'd1);
    wait_done("tp3_done_seen", 100);
    check_val("tp3_armed_drop", 32'(armed), 32'd0);
    tick();
    pulse_match();
    check_val("tp3_second_busy", 32'(busy), 32'd0);
`ifdef PW_TRIG_MISSED_CNT_EN
    check_val("tp3_missed", 32'(missed), 32'd2);
`endif
    oneshot = 1'b0;
    repeat (2) tick();

    // Abort during second high phase of a three-pulse train.
    set_uniform(1, 3, 3);
    pulse_match();
    repeat (5) tick();
    check_val("tp4_second_high", 32'(trig), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    check_val("tp4_trig", 32'(trig), 32'd0);
    check_val("tp4_busy", 32'(busy), 32'd0);
    check_val("tp4_index", 32'(pidx), 32'd1);
    check_val("tp4_done", 32'(done), 32'd0);
    repeat (10) tick();

    // Clamp of pulse count to 8, and zero count.
    set_uniform(1, 1, 15);
    match = 1'b1;
    cnt = 0; prev = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      match = 1'b0;
      if (trig && !prev) cnt++;
      prev = int'(trig);
      if (done) break;
    end
    check_val("tp5_pulses", 32'(cnt), 32'd8);
    set_uniform(1, 1, 0);
    pulse_match();
    tick();
    check_val("tp5_zero_busy", 32'(busy), 32'd0);

    // Snapshot: width changes mid-train only affect the next train.
    set_uniform(1, 2, 2);
    match = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      match = 1'b0;
      if (i == 1) set_uniform(1, 7, 2);
      if (trig) cnt++;
      if (done) break;
    end
    check_val("tp6_old_high_cycles", 32'(cnt), 32'd4);
    match = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      match = 1'b0;
      if (trig) cnt++;
      if (done) break;
    end
    check_val("tp6_new_high_cycles", 32'(cnt), 32'd14);

    // Random phase, including all-ones delays/widths and out-of-range counts.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < NP; k++) begin
          tdelay[k*DW +: DW] = ($urandom_range(0, 9) == 0) ? DW'(31) : DW'($urandom_range(0, 3));
          twidth[k*WW +: WW] = ($urandom_range(0, 9) == 0) ? WW'(15) : WW'($urandom_range(0, 3));
        end
        ntrig = NW'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 49) == 0) oneshot = ~oneshot;
      en      = ($urandom_range(0, 9) != 0);
      match   = ($urandom_range(0, 5) == 0);
      arm     = ($urandom_range(0, 14) == 0);
      abort   = ($urandom_range(0, 79) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
